// File: rtl/parking_pkg.sv
// Shared request encodings, floor limits and plate validation for the parking request queue.
package parking_pkg;

    localparam int PLATE_W    = 16;
    localparam int NUM_FLOORS = 7;
    localparam int FLOOR_W    = 3;

    typedef enum logic [1:0] {
        REQ_IN   = 2'b01,
        REQ_OUT  = 2'b10,
        REQ_LEAK = 2'b11
    } req_kind_t;

    // A plate is four BCD digits; any nibble above 9 makes it unusable.
    function automatic logic is_bcd_plate(input logic [PLATE_W-1:0] plate);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < PLATE_W / 4; i++) begin
            if (plate[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/parking_req_fifo.sv
// Synchronous FIFO of {kind, plate} jobs with occupancy count.
// With PARKING_QUEUE_DEDUP_EN defined it also reports whether cmp_data matches a live entry.
module parking_req_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [4:0]       count,
    output logic             full,
    output logic             empty
`ifdef PARKING_QUEUE_DEDUP_EN
    ,
    input  logic [WIDTH-1:0] cmp_data,
    output logic             cmp_hit
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [4:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == 5'(DEPTH));
    assign empty     = (count_reg == 5'd0);
    assign count     = count_reg;
    assign head_data = mem[rd_ptr_reg];
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 5'd1;
                2'b01:   count_reg <= count_reg - 5'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

`ifdef PARKING_QUEUE_DEDUP_EN
    // An entry is live if it sits within count of the head and is not leaving this cycle.
    logic [DEPTH-1:0] hit_vec;
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        logic [AW-1:0] offset;
        logic          live;
        assign offset      = AW'(gi) - rd_ptr_reg;
        assign live        = (5'(offset) < count_reg) && !(do_pop && (offset == '0));
        assign hit_vec[gi] = live && (mem[gi] == cmp_data);
    end
    assign cmp_hit = |hit_vec;
`endif

endmodule

// File: rtl/parking_request_queue.sv
// Validates in/out/leak requests, buffers in/out jobs and presents one job at a time (leak first).
// Define PARKING_QUEUE_DEDUP_EN to drop requests whose plate and kind already wait in the FIFO.
module parking_request_queue #(
    parameter int DEPTH   = 8,
    parameter int PLATE_W = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [PLATE_W-1:0] license_plate,
    input  logic               in_mode,
    input  logic               out_mode,
    input  logic               leakage,
    input  logic [2:0]         leakage_floor,
    input  logic               pop,
    output logic               todo_exists,
    output logic               todo_in,
    output logic               todo_out,
    output logic               todo_leak_move,
    output logic [PLATE_W-1:0] todo_license_plate,
    output logic [2:0]         todo_leak_floor,
    output logic [4:0]         count,
    output logic               req_error,
    output logic [7:0]         drop_cnt
);
    import parking_pkg::*;

    logic [1:0]         rst_sync_reg;
    logic               rst_n_int;
    logic               leak_prev_reg;
    logic [FLOOR_W-1:0] floor_prev_reg;
    logic               leak_valid_reg;
    logic [FLOOR_W-1:0] leak_floor_reg;
    logic               req_error_reg;
    logic [7:0]         drop_cnt_reg;

    logic               leak_event;
    logic               req_any;
    logic               req_legal;
    req_kind_t          req_kind;
    logic               pop_eff;
    logic               pop_leak;
    logic               pop_fifo;
    logic               fifo_push;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [PLATE_W+1:0] fifo_head;
    logic [1:0]         head_kind;

    // Reset asserts immediately but releases only after two clean clock edges.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rst_sync_reg <= 2'b00;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
        end
    end
    assign rst_n_int = rst_sync_reg[1];

    assign leak_event = leakage && (!leak_prev_reg || (leakage_floor != floor_prev_reg))
                        && (leakage_floor != '0) && (int'(leakage_floor) <= NUM_FLOORS);

    assign req_any   = in_mode || out_mode;
    assign req_kind  = in_mode ? REQ_IN : REQ_OUT;
    assign req_legal = (in_mode ^ out_mode) && is_bcd_plate(license_plate)
                       && (license_plate != '0);

    assign pop_eff  = pop && todo_exists;
    assign pop_leak = pop_eff && leak_valid_reg;
    assign pop_fifo = pop_eff && !leak_valid_reg;

`ifdef PARKING_QUEUE_DEDUP_EN
    logic dup_hit;
`else
    localparam logic dup_hit = 1'b0;
`endif

    assign fifo_push = req_any && req_legal && (!fifo_full || pop_fifo) && !dup_hit;
    assign drop      = req_any && !fifo_push;

    parking_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PLATE_W + 2)
    ) u_fifo (
        .clock     (clock),
        .rst_n     (rst_n_int),
        .push      (fifo_push),
        .push_data ({req_kind, license_plate}),
        .pop       (pop_fifo),
        .head_data (fifo_head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
`ifdef PARKING_QUEUE_DEDUP_EN
        ,
        .cmp_data  ({req_kind, license_plate}),
        .cmp_hit   (dup_hit)
`endif
    );

    // A new leak event wins over a same-cycle pop of the old one.
    always_ff @(posedge clock or negedge rst_n_int) begin
        if (!rst_n_int) begin
            leak_prev_reg  <= 1'b0;
            floor_prev_reg <= '0;
            leak_valid_reg <= 1'b0;
            leak_floor_reg <= '0;
            req_error_reg  <= 1'b0;
            drop_cnt_reg   <= '0;
        end else begin
            leak_prev_reg  <= leakage;
            floor_prev_reg <= leakage_floor;
            if (leak_event) begin
                leak_valid_reg <= 1'b1;
                leak_floor_reg <= leakage_floor;
            end else if (pop_leak) begin
                leak_valid_reg <= 1'b0;
            end
            req_error_reg <= drop;
            if (drop && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end
    end

    assign req_error = req_error_reg;
    assign drop_cnt  = drop_cnt_reg;
    assign head_kind = fifo_head[PLATE_W +: 2];

    always_comb begin
        todo_exists        = 1'b0;
        todo_in            = 1'b0;
        todo_out           = 1'b0;
        todo_leak_move     = 1'b0;
        todo_license_plate = '0;
        todo_leak_floor    = '0;
        if (leak_valid_reg) begin
            todo_exists     = 1'b1;
            todo_leak_move  = 1'b1;
            todo_leak_floor = leak_floor_reg;
        end else if (!fifo_empty) begin
            todo_exists        = 1'b1;
            todo_in            = (head_kind == REQ_IN);
            todo_out           = (head_kind == REQ_OUT);
            todo_license_plate = fifo_head[PLATE_W-1:0];
        end
    end

endmodule

// File: tb/tb_parking_request_queue.sv
// Scoreboard bench for parking_request_queue: a queue-based job model predicts every cycle's outputs.
module tb_parking_request_queue;

    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] license_plate = '0;
    logic        in_mode = 1'b0;
    logic        out_mode = 1'b0;
    logic        leakage = 1'b0;
    logic [2:0]  leakage_floor = '0;
    logic        pop = 1'b0;
    logic        todo_exists;
    logic        todo_in;
    logic        todo_out;
    logic        todo_leak_move;
    logic [15:0] todo_license_plate;
    logic [2:0]  todo_leak_floor;
    logic [4:0]  count;
    logic        req_error;
    logic [7:0]  drop_cnt;

    parking_request_queue #(.DEPTH(DEPTH), .PLATE_W(16)) dut (
        .clock              (clock),
        .reset              (reset),
        .license_plate      (license_plate),
        .in_mode            (in_mode),
        .out_mode           (out_mode),
        .leakage            (leakage),
        .leakage_floor      (leakage_floor),
        .pop                (pop),
        .todo_exists        (todo_exists),
        .todo_in            (todo_in),
        .todo_out           (todo_out),
        .todo_leak_move     (todo_leak_move),
        .todo_license_plate (todo_license_plate),
        .todo_leak_floor    (todo_leak_floor),
        .count              (count),
        .req_error          (req_error),
        .drop_cnt           (drop_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        int        kind;   // 1 = park in, 2 = retrieve out
        bit [15:0] plate;
    } job_t;

    typedef struct {
        bit        exists;
        bit        tin;
        bit        tout;
        bit        tleak;
        bit [15:0] plate;
        bit [2:0]  floor;
        int        cnt;
        bit        err;
        int        drops;
    } snap_t;

    int    tests_run    = 0;
    int    tests_failed = 0;
    snap_t exp_q[$];

    job_t     jobs[$];
    bit       m_leak_valid;
    bit [2:0] m_leak_floor;
    bit       m_prev_lk;
    bit [2:0] m_prev_fl;
    int       m_drops;
    bit       m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bcd_ok(input bit [15:0] p);
        for (int d = 0; d < 4; d++) begin
            if (((p >> (4 * d)) & 16'hF) > 9) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic snap_t mk_snap();
        snap_t s;
        s.exists = m_leak_valid || (jobs.size() > 0);
        s.tleak  = m_leak_valid;
        s.tin    = !m_leak_valid && (jobs.size() > 0) && (jobs[0].kind == 1);
        s.tout   = !m_leak_valid && (jobs.size() > 0) && (jobs[0].kind == 2);
        s.plate  = (!m_leak_valid && jobs.size() > 0) ? jobs[0].plate : 16'h0;
        s.floor  = m_leak_valid ? m_leak_floor : 3'd0;
        s.cnt    = jobs.size();
        s.err    = m_err;
        s.drops  = m_drops;
        return s;
    endfunction

    task automatic model_reset();
        jobs.delete();
        m_leak_valid = 0;
        m_leak_floor = 0;
        m_prev_lk    = 0;
        m_prev_fl    = 0;
        m_drops      = 0;
        m_err        = 0;
    endtask

    task automatic model_step(input bit im, input bit om, input bit [15:0] pl,
                              input bit lk, input bit [2:0] fl, input bit pp);
        bit   pop_leak, pop_job, legal, dup;
        job_t nj;
        pop_leak = pp && m_leak_valid;
        pop_job  = pp && !m_leak_valid && (jobs.size() > 0);
        m_err    = 0;
        dup      = 0;
        if (im || om) begin
            legal = (im != om) && (pl != 0) && bcd_ok(pl);
`ifdef PARKING_QUEUE_DEDUP_EN
            for (int i = (pop_job ? 1 : 0); i < jobs.size(); i++) begin
                if (jobs[i].plate == pl && jobs[i].kind == (im ? 1 : 2)) dup = 1;
            end
`endif
            if (legal && !dup && (jobs.size() - (pop_job ? 1 : 0)) < DEPTH) begin
                nj.kind  = im ? 1 : 2;
                nj.plate = pl;
            end else begin
                m_err = 1;
            end
        end
        if (pop_job) begin
            $display("[TB] t=%0t pop %s plate=%h", $time, jobs[0].kind == 1 ? "in " : "out",
                     jobs[0].plate);
            void'(jobs.pop_front());
        end
        if ((im || om) && !m_err) jobs.push_back(nj);
        if (pop_leak) begin
            $display("[TB] t=%0t pop leak floor=%0d", $time, m_leak_floor);
            m_leak_valid = 0;
        end
        if (lk && fl != 0 && (!m_prev_lk || fl != m_prev_fl)) begin
            m_leak_valid = 1;
            m_leak_floor = fl;
        end
        m_prev_lk = lk;
        m_prev_fl = fl;
        if (m_err && m_drops < 255) m_drops++;
    endtask

    task automatic drive(input bit im, input bit om, input bit [15:0] pl,
                         input bit lk, input bit [2:0] fl, input bit pp);
        @(negedge clock);
        in_mode       = im;
        out_mode      = om;
        license_plate = pl;
        leakage       = lk;
        leakage_floor = fl;
        pop           = pp;
        model_step(im, om, pl, lk, fl, pp);
        exp_q.push_back(mk_snap());
    endtask

    task automatic do_reset(input int hold);
        @(negedge clock);
        reset = 1'b0;
        in_mode = 0; out_mode = 0; license_plate = 0; leakage = 0; leakage_floor = 0; pop = 0;
        model_reset();
        #1;
        chk("async_rst_exists", todo_exists, 0);
        chk("async_rst_count", count, 0);
        chk("async_rst_drop_cnt", drop_cnt, 0);
        exp_q.push_back(mk_snap());
        repeat (hold - 1) begin
            @(negedge clock);
            exp_q.push_back(mk_snap());
        end
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(mk_snap());
        repeat (3) begin
            @(negedge clock);
            exp_q.push_back(mk_snap());
        end
    endtask

    // Monitor: compares each post-edge DUT state with the next expected snapshot.
    initial begin
        snap_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("todo_exists", todo_exists, e.exists);
                chk("todo_in", todo_in, e.tin);
                chk("todo_out", todo_out, e.tout);
                chk("todo_leak_move", todo_leak_move, e.tleak);
                chk("todo_plate", todo_license_plate, e.plate);
                chk("todo_leak_floor", todo_leak_floor, e.floor);
                chk("count", count, e.cnt);
                chk("req_error", req_error, e.err);
                chk("drop_cnt", drop_cnt, e.drops);
            end
        end
    end

    initial begin
        bit [15:0] pool [6];
        bit        lk_lvl;
        bit [2:0]  fl;
        pool = '{16'h1234, 16'h9999, 16'h0001, 16'h5755, 16'h8754, 16'h4260};
        model_reset();
        #2 reset = 1'b0;
        do_reset(3);

        // Single park-in request.
        drive(1, 0, 16'h9423, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 1);
        // In/in/out then three pops in order.
        drive(1, 0, 16'h9423, 0, 0, 0);
        drive(1, 0, 16'h8754, 0, 0, 0);
        drive(0, 1, 16'h8754, 0, 0, 0);
        repeat (3) drive(0, 0, 16'h0, 0, 0, 1);
        drive(0, 0, 16'h0, 0, 0, 0);
        // Fill, overflow, push+pop while full.
        for (int i = 1; i <= DEPTH; i++) drive(1, 0, 16'h1000 + 16'(i), 0, 0, 0);
        drive(1, 0, 16'h2000, 0, 0, 0);
        drive(0, 1, 16'h2001, 0, 0, 1);
        // Leak preempts FIFO head, then pop returns to FIFO.
        repeat (DEPTH - 2) drive(0, 0, 16'h0, 0, 0, 1);
        drive(0, 0, 16'h0, 1, 3'd3, 0);
        drive(0, 0, 16'h0, 1, 3'd3, 0);
        drive(0, 0, 16'h0, 1, 3'd3, 1);
        drive(0, 0, 16'h0, 0, 3'd0, 0);
        // Illegal requests and a floor-0 leak edge.
        drive(1, 1, 16'h1111, 0, 0, 0);
        drive(1, 0, 16'h5A55, 1, 3'd0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        // Repeated plate, then asynchronous reset mid-run.
        drive(1, 0, 16'h5755, 0, 0, 0);
        drive(1, 0, 16'h5755, 0, 0, 0);
        drive(0, 0, 16'h0, 0, 0, 0);
        do_reset(2);

        // Drive enough drops to saturate the counter.
        for (int i = 0; i < 270; i++) drive(1, 1, 16'h1111, 0, 0, 1'($urandom_range(0, 1)));

        lk_lvl = 0;
        fl = 3'd1;
        for (int c = 0; c < 1500; c++) begin
            int        r;
            bit        im, om, pp;
            bit [15:0] pl;
            r  = $urandom_range(0, 99);
            im = (r < 30) || (r >= 55 && r < 58);
            om = (r >= 30 && r < 58);
            pl = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 5)] : 16'($urandom);
            if ($urandom_range(0, 19) == 0) lk_lvl = !lk_lvl;
            if ($urandom_range(0, 9) == 0) fl = 3'($urandom_range(0, 7));
            pp = ($urandom_range(0, 99) < 35);
            drive(im, om, pl, lk_lvl, fl, pp);
            if (c == 700) begin
                do_reset(2);
                lk_lvl = 0;
            end
        end
        drive(0, 0, 16'h0, 0, 0, 0);

        @(posedge clock);
        #2;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
